// File: rtl/pulse_stretch_pkg.sv
// Shared lane state encodings and hold-off sizing for the pulse stretcher.
// The lanes and the top level both import this package.

package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } lane_state_t;

  localparam int HOLD_BITS = 8;
  localparam int HOLD_MAX  = (1 << HOLD_BITS) - 1;

  // Hold-off counter reload value; a zero gap never enters the hold-off state.
  function automatic int hold_load(input int holdoff);
    return (holdoff > 0) ? holdoff - 1 : 0;
  endfunction

endpackage

// File: rtl/pulse_stretch_lane.sv
// One stretcher lane: turns a qualified strobe into a pulse of a preloaded
// length, with optional retrigger and an optional low hold-off gap.

module pulse_stretch_lane
  import pulse_stretch_pkg::*;
#(
  parameter int WIDTH_BITS = 8,
  parameter int RETRIGGER  = 1,
  parameter int HOLDOFF    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic [WIDTH_BITS-1:0] load_cnt,
  output logic                  out,
  output logic                  drop,
  output logic                  idle
);

  localparam bit                 RETRIG_EN = (RETRIGGER != 0);
  localparam bit                 HOLD_EN   = (HOLDOFF > 0);
  localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(hold_load(HOLDOFF));

  lane_state_t           state_q, state_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [HOLD_BITS-1:0]  hcnt_q, hcnt_d;
  logic                  drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      drop_q  <= drop_d;
    end
  end

  // A strobe arriving in the last hold-off cycle is taken, so the lane can
  // restart immediately after the gap without a dead IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          state_d = ST_ACTIVE;
          cnt_d   = load_cnt;
        end
      end
      ST_ACTIVE: begin
        if (strobe && RETRIG_EN) begin
          cnt_d = load_cnt;
        end else begin
          drop_d = strobe;
          if (cnt_q == '0) begin
            if (HOLD_EN) begin
              state_d = ST_HOLDOFF;
              hcnt_d  = HOLD_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - WIDTH_BITS'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == '0) begin
          if (strobe) begin
            state_d = ST_ACTIVE;
            cnt_d   = load_cnt;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q - HOLD_BITS'(1);
          drop_d = strobe;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out  = (state_q == ST_ACTIVE);
  assign drop = drop_q;
  // Next-state idle lets the top register busy in step with pulse_out.
  assign idle = (state_d == ST_IDLE);

endmodule

// File: rtl/pulse_stretch.sv
// Multi-lane pulse stretcher: each lane rebuilds a pulse of the runtime
// width from a single-cycle strobe; busy reports any lane still working.

module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH_BITS = 8,
  parameter int RETRIGGER  = 1,
  parameter int HOLDOFF    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH_BITS-1:0] width,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] pulse_out,
  output logic [DATA_WIDTH-1:0] drop,
  output logic                  busy
);

  if (HOLDOFF < 0 || HOLDOFF > HOLD_MAX) begin : g_holdoff_check
    $fatal(1, "pulse_stretch: HOLDOFF must be in 0..255");
  end

  logic [WIDTH_BITS-1:0] weff;
  logic [WIDTH_BITS-1:0] load_cnt;
  logic [DATA_WIDTH-1:0] lane_idle;
  logic                  busy_q;

  // A zero width still produces a one-cycle pulse; lanes count down to zero.
  assign weff     = (width == '0) ? WIDTH_BITS'(1) : width;
  assign load_cnt = weff - WIDTH_BITS'(1);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    pulse_stretch_lane #(
      .WIDTH_BITS (WIDTH_BITS),
      .RETRIGGER  (RETRIGGER),
      .HOLDOFF    (HOLDOFF)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .strobe   (in[i] & en),
      .load_cnt (load_cnt),
      .out      (pulse_out[i]),
      .drop     (drop[i]),
      .idle     (lane_idle[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= ~&lane_idle;
    end
  end

  assign busy = busy_q;

endmodule
